inst_fetch_sequencer: RTL
=========================

// Module: inst_fetch_sequencer
// PURPOSE
// Front-end PC sequencer and instruction fetcher. Owns the program counter, fetches one
// instruction word per request from instruction memory over a req/ack interface, and
// presents it to decode with its PC and branch-offset fields (inst_1, inst_2, jump) over
// a valid/ready handshake. It redirects to branch_addr, the target computed by the
// branch adder from the pc/inst fields that this block produces.
// PARAMETERS
// INST_ADDR_WIDTH  16  PC / instruction-memory address width (words)
// INST_WIDTH       16  instruction word width; must be >= INST_2_WIDTH + 1
// INST_1_WIDTH      8  short branch offset field = inst[INST_1_WIDTH-1:0]
// INST_2_WIDTH     12  long branch offset field = inst[INST_2_WIDTH-1:0]
// RESET_PC          0  fetch address after reset
// PORTS
// clk          in   1                clock, all state updates on posedge
// rst          in   1                asynchronous, active-high reset
// imem_req     out  1                fetch request, high in REQ state only
// imem_addr    out  INST_ADDR_WIDTH  fetch address (fetch_pc)
// imem_ack     in   1                request completes in any cycle with imem_req & imem_ack
// imem_data    in   INST_WIDTH       instruction word, valid with imem_ack
// inst_valid   out  1                inst/pc/fields valid to decode
// inst_ready   in   1                decode accepts when inst_valid & inst_ready
// inst         out  INST_WIDTH       registered instruction word
// inst_1       out  INST_1_WIDTH     inst[INST_1_WIDTH-1:0]
// inst_2       out  INST_2_WIDTH     inst[INST_2_WIDTH-1:0]
// jump         out  1                inst[INST_WIDTH-1] (long-branch select for the branch adder)
// pc           out  INST_ADDR_WIDTH  address of the instruction presented on inst
// branch_taken in   1                redirect request, single-cycle pulse
// branch_addr  in   INST_ADDR_WIDTH  redirect target, sampled when branch_taken=1
// BEHAVIOUR
// - Reset (async): state=IDLE, fetch_pc=RESET_PC, pc=RESET_PC, inst=0, inst_valid=0, imem_req=0.
// - FSM: IDLE -> REQ (unconditional, first clk after reset release).
//   REQ: imem_req=1, imem_addr=fetch_pc. On imem_ack: inst<=imem_data, pc<=fetch_pc, -> HOLD.
//   HOLD: inst_valid=1, imem_req=0. On inst_ready: fetch_pc<=fetch_pc+1, -> REQ.
// - Outputs imem_req, inst_valid decode from state only (Moore); no comb path from inputs.
// - Memory protocol is non-committing: the request is only consumed in the ack cycle; addr
//   may change/req may drop in any cycle without ack. Ack while imem_req=0 is ignored.
// - Latency: ack in cycle N -> inst_valid=1 in N+1; accept in N -> imem_req=1 in N+1.
//   Peak throughput: one instruction per 2 cycles with zero-wait memory.
// - branch_taken (any state, highest priority): fetch_pc<=branch_addr, state<=REQ,
//   inst_valid=0 next cycle. Same-cycle imem_ack data discarded; same-cycle inst_ready
//   still counts as accepted by decode, but fetch_pc does not increment.
//   branch_taken in IDLE: load target, -> REQ.
// - fetch_pc+1 wraps modulo 2^INST_ADDR_WIDTH (max -> 0), no flag.
// - inst/pc hold stable while inst_valid=1 & inst_ready=0.
// - Mid-operation reset: all state cleared immediately; outstanding fetch abandoned.
// TESTING
// 1. Release rst, ack first req with 16'h80FF -> imem_addr=0; next cycle inst_valid=1,
//    pc=0, inst_1=8'hFF, inst_2=12'h0FF, jump=1.
// 2. inst_ready=1, imem_ack=1 constantly -> imem_addr 0,1,2,3 on alternating cycles; pc tracks.
// 3. Hold inst_ready=0 for 5 cycles in HOLD -> inst, pc stable; imem_req stays 0.
// 4. In REQ, branch_taken=1, branch_addr=1000, imem_ack=1 same cycle -> data dropped,
//    inst_valid stays 0, next imem_addr=1000.
// 5. In HOLD, branch_taken with inst_ready=1 -> inst_valid 0 next cycle, imem_addr=1000 (not pc+1).
// 6. RESET_PC=16'hFFFF: accept first inst -> next imem_addr=0; assert rst in HOLD -> all outputs reset.

Source files
------------

// File: rtl/inst_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// inst_fetch_sequencer
//
// Front-end PC sequencer and instruction fetcher. Owns the fetch program
// counter, fetches one instruction word per request from instruction memory
// over a req/ack interface, and presents it to decode together with its PC and
// the branch-offset fields over a valid/ready handshake. A single-cycle
// branch_taken pulse redirects fetch to branch_addr from any state.
//
// Ports
//   clk, rst           clock / asynchronous active-high reset
//   imem_req/addr      fetch request and address (request only in REQ state)
//   imem_ack/data      fetch completion and returned instruction word
//   inst_valid/ready   decode handshake
//   inst, pc           registered instruction word and its address
//   inst_1, inst_2     short / long branch offset fields of inst
//   jump               inst MSB, long-branch select for the branch adder
//   branch_taken/addr  redirect pulse and target
// -----------------------------------------------------------------------------
module inst_fetch_sequencer #(
  parameter int unsigned                   INST_ADDR_WIDTH = 16,
  parameter int unsigned                   INST_WIDTH      = 16,
  parameter int unsigned                   INST_1_WIDTH    = 8,
  parameter int unsigned                   INST_2_WIDTH    = 12,
  parameter logic [INST_ADDR_WIDTH-1:0]    RESET_PC        = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  input  logic                       imem_ack,
  input  logic [INST_WIDTH-1:0]      imem_data,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [INST_WIDTH-1:0]      inst,
  output logic [INST_1_WIDTH-1:0]    inst_1,
  output logic [INST_2_WIDTH-1:0]    inst_2,
  output logic                       jump,
  output logic [INST_ADDR_WIDTH-1:0] pc,
  input  logic                       branch_taken,
  input  logic [INST_ADDR_WIDTH-1:0] branch_addr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [INST_ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [INST_ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0]        inst_q, inst_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
    end
  end

  // Next-state logic. A redirect overrides everything: ack data arriving in
  // the same cycle is dropped, and a same-cycle decode accept does not bump
  // fetch_pc because the target replaces it.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    if (branch_taken) begin
      state_d    = S_REQ;
      fetch_pc_d = branch_addr;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            inst_d  = imem_data;
            pc_d    = fetch_pc_q;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            // Wraps modulo 2^INST_ADDR_WIDTH.
            fetch_pc_d = fetch_pc_q + 1'b1;
            state_d    = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Moore outputs: handshake strobes depend on state only.
  always_comb begin
    imem_req   = (state_q == S_REQ);
    inst_valid = (state_q == S_HOLD);
  end

  assign imem_addr = fetch_pc_q;
  assign pc        = pc_q;
  assign inst      = inst_q;
  assign inst_1    = inst_q[INST_1_WIDTH-1:0];
  assign inst_2    = inst_q[INST_2_WIDTH-1:0];
  assign jump      = inst_q[INST_WIDTH-1];

endmodule
